// File: rtl/console_uart_tx_pkg.sv
// Shared types and constants for the console UART transmitter.
// Line-state encoding plus a helper mapping FSM state to the tx level.
package console_uart_tx_pkg;

  localparam int UART_STATE_LEN = 2;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [UART_STATE_LEN-1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  function automatic logic line_level(
    input uart_state_e s,
    input logic        b
  );
    logic lvl;
    lvl = 1'b1;
    unique case (s)
      UART_START: lvl = 1'b0;
      UART_DATA:  lvl = b;
      default:    lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/console_uart_tx_fifo.sv
// Byte FIFO between the console write port and the UART serialiser.
// full/empty are registered from the next occupancy count.
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_d;

  assign w_push = push & ~r_full;
  assign w_pop  = pop & ~r_empty;

  always_comb begin
    w_cnt_d = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_d = r_cnt + CW'(1);
      2'b01:   w_cnt_d = r_cnt - CW'(1);
      default: w_cnt_d = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_d;
      r_full  <= (w_cnt_d == CW'(DEPTH));
      r_empty <= (w_cnt_d == '0);
    end
  end

  // Storage needs no reset: only entries behind r_cnt are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wdata;
  end

  assign rdata = r_mem[r_rp];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/console_uart_tx.sv
// Console byte sink: buffers writes and sends them as 8N1 UART frames.
// tx comes from a register loaded with the level of the next state.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            console_we,
  input  logic [XLEN-1:0] console_wdata,
  output logic            full,
  output logic            busy,
  output logic            overflow,
  output logic            tx
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(CLK_DIV - 1);
  localparam logic [UART_IDX_W-1:0] LAST_BIT =
    UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e           r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [7:0]            r_shift;
  logic [UART_IDX_W-1:0] r_idx;
  logic                  r_tx;
  logic                  r_ovf;

  uart_state_e           w_state_d;
  logic [CNT_W-1:0]      w_cnt_d;
  logic [7:0]            w_shift_d;
  logic [UART_IDX_W-1:0] w_idx_d;
  logic                  w_tx_d;
  logic                  w_tick;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_rdata;
  logic                  w_unused;

  assign w_unused = ^console_wdata[XLEN-1:8];
  assign w_push   = console_we & ~w_full;

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (console_wdata[7:0]),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_shift_d = r_shift;
    w_idx_d   = r_idx;
    w_pop     = 1'b0;
    unique case (r_state)
      UART_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_rdata;
          w_cnt_d   = RELOAD;
          w_state_d = UART_START;
        end
      end
      UART_START: begin
        if (w_tick) begin
          w_cnt_d   = RELOAD;
          w_idx_d   = '0;
          w_state_d = UART_DATA;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      UART_DATA: begin
        if (w_tick) begin
          w_cnt_d   = RELOAD;
          w_shift_d = {1'b0, r_shift[7:1]};
          if (r_idx == LAST_BIT) begin
            w_state_d = UART_STOP;
          end else begin
            w_idx_d = r_idx + UART_IDX_W'(1);
          end
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      UART_STOP: begin
        // Chain straight into the next start bit when data waits.
        if (w_tick) begin
          w_cnt_d = RELOAD;
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_rdata;
            w_state_d = UART_START;
          end else begin
            w_state_d = UART_IDLE;
          end
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_d = UART_IDLE;
    endcase
    w_tx_d = line_level(w_state_d, w_shift_d[0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= UART_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
      r_idx   <= w_idx_d;
      r_tx    <= w_tx_d;
      r_ovf   <= r_ovf | (console_we & w_full);
    end
  end

  assign full     = w_full;
  assign busy     = (r_state != UART_IDLE) | ~w_empty;
  assign overflow = r_ovf;
  assign tx       = r_tx;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: frame timing model driven by write schedules.
// Expected line state derives from accept/start times of each byte.
module tb_console_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic        clk;
  logic        reset;
  logic        console_we;
  logic [31:0] console_wdata;
  logic        full;
  logic        busy;
  logic        overflow;
  logic        tx;

  int checks;
  int errors;

  int          wr_at[$];
  logic [31:0] wr_dat[$];

  console_uart_tx #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH),
    .XLEN       (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .console_we    (console_we),
    .console_wdata (console_wdata),
    .full          (full),
    .busy          (busy),
    .overflow      (overflow),
    .tx            (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    console_we = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Edge 0 is the first rising edge after the call.
  task automatic run_sched(input string nm, input int n);
    int          acc[$];
    int          st[$];
    logic [7:0]  by[$];
    int          ovf_t;
    int          prev_end;
    int          wi;
    ovf_t    = 32'h7fffffff;
    prev_end = 0;
    foreach (wr_at[i]) begin
      int w;
      int occ;
      w   = wr_at[i];
      occ = acc.size();
      foreach (st[k]) if (st[k] < w) occ--;
      if (occ < DEPTH) begin
        acc.push_back(w);
        st.push_back((w + 1 > prev_end) ? w + 1 : prev_end);
        prev_end = st[$] + FRAME;
        by.push_back(wr_dat[i][7:0]);
      end else if (w < ovf_t) begin
        ovf_t = w;
      end
    end
    wi = 0;
    for (int t = 0; t < n; t++) begin
      int   occ;
      int   b;
      logic etx;
      logic inf;
      logic ebusy;
      logic efull;
      logic eovf;
      console_we    = 1'b0;
      console_wdata = $urandom;
      if (wi < wr_at.size() && wr_at[wi] == t) begin
        console_we    = 1'b1;
        console_wdata = wr_dat[wi];
        wi++;
      end
      @(posedge clk);
      #1;
      occ = 0;
      etx = 1'b1;
      inf = 1'b0;
      foreach (acc[k]) begin
        if (acc[k] <= t) occ++;
        if (st[k] <= t) occ--;
        if (t >= st[k] && t < st[k] + FRAME) begin
          inf = 1'b1;
          b   = (t - st[k]) / DIV;
          if (b == 0)      etx = 1'b0;
          else if (b == 9) etx = 1'b1;
          else             etx = by[k][b-1];
        end
      end
      ebusy = inf | (occ > 0);
      efull = (occ == DEPTH);
      eovf  = (t >= ovf_t);
      checks += 4;
      if (tx !== etx) begin
        errors++;
        $display("FAIL %s tx t=%0d got %b exp %b",
                 nm, t, tx, etx);
      end
      if (busy !== ebusy) begin
        errors++;
        $display("FAIL %s busy t=%0d got %b exp %b",
                 nm, t, busy, ebusy);
      end
      if (full !== efull) begin
        errors++;
        $display("FAIL %s full t=%0d got %b exp %b",
                 nm, t, full, efull);
      end
      if (overflow !== eovf) begin
        errors++;
        $display("FAIL %s ovf t=%0d got %b exp %b",
                 nm, t, overflow, eovf);
      end
    end
    console_we = 1'b0;
    wr_at.delete();
    wr_dat.delete();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx, full, busy, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async got %b exp 1000",
               {tx, full, busy, overflow});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx, full, busy, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hold got %b exp 1000",
               {tx, full, busy, overflow});
    end
    reset = 1'b1;
    run_sched("idle", 100);
  endtask

  task automatic test_single();
    do_reset();
    wr_at.push_back(0);
    wr_dat.push_back(32'h0000_0041);
    run_sched("single", FRAME + 10);
  endtask

  task automatic test_width_mask();
    do_reset();
    wr_at.push_back(0);
    wr_dat.push_back(32'hFFFF_FF41);
    run_sched("mask", FRAME + 10);
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_at.push_back(0);
    wr_dat.push_back(32'h55);
    wr_at.push_back(1);
    wr_dat.push_back(32'hAA);
    run_sched("b2b", 2 * FRAME + 10);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_at.push_back(i);
      wr_dat.push_back(32'h30 + i);
    end
    run_sched("ovf", 6 * FRAME + 20);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int t;
      int nw;
      do_reset();
      t  = $urandom_range(0, 5);
      nw = $urandom_range(6, 10);
      for (int i = 0; i < nw; i++) begin
        wr_at.push_back(t);
        wr_dat.push_back($urandom);
        if ($urandom_range(0, 2) == 0) t += 1;
        else t += $urandom_range(1, 50);
      end
      run_sched("rand", t + 11 * FRAME + 20);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_at.push_back(0);
    wr_dat.push_back(32'h41);
    wr_at.push_back(1);
    wr_dat.push_back(32'hB2);
    wr_at.push_back(2);
    wr_dat.push_back(32'hC3);
    run_sched("mid_pre", 19);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx, busy, full} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset got %b exp 100",
               {tx, busy, full});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tx, busy, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL mid_hold got %b exp 100",
               {tx, busy, overflow});
    end
    reset = 1'b1;
    run_sched("mid_post", 100);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    console_we    = 1'b0;
    console_wdata = '0;
    test_reset();
    test_single();
    test_width_mask();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
